// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_param
//  Purpose  : Parametrised oversampling UART receiver. It uses a 3-sample
//             majority vote per bit, rejects false starts, and delivers each
//             word through a valid/ready handshake with parity, framing and
//             overrun flags.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_param #(
   parameter int DATA_BITS   = 8,
   parameter int OVERSAMPLE  = 16,
   parameter int PARITY      = 0,
   parameter int STOP_BITS   = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 baud_tick,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] ext_data_out,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun_err
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS + 1);

   // Sample points sit around mid-bit; the third one carries the vote.
   localparam logic [TW-1:0] c_SAMP_A    = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] c_SAMP_B    = TW'(OVERSAMPLE / 2);
   localparam logic [TW-1:0] c_SAMP_C    = TW'(OVERSAMPLE / 2 + 1);
   localparam logic [TW-1:0] c_TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] c_NBITS     = BW'(DATA_BITS);
   localparam logic          c_LAST_STOP = 1'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4,
      S_BREAK  = 3'd5
   } state_t;

   state_t                 state_q;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [TW-1:0]          tick_q;
   logic [BW-1:0]          bit_q;
   logic                   stop_q;
   logic [1:0]             samp_q;
   logic [DATA_BITS-1:0]   shift_q;
   logic                   perr_q;
   logic                   ferr_q;

   logic w_rxs;
   logic w_tick_a;
   logic w_tick_b;
   logic w_vote_pt;
   logic w_bit_end;
   logic w_vote;
   logic w_par_err;

   // Bring rx into the clk domain; flops reset to the idle (high) line level.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      end
   end

   // Decode sample/vote/bit-end points and form the 2-of-3 majority.
   always_comb begin
      w_rxs     = sync_q[SYNC_STAGES-1];
      w_tick_a  = baud_tick && (tick_q == c_SAMP_A);
      w_tick_b  = baud_tick && (tick_q == c_SAMP_B);
      w_vote_pt = baud_tick && (tick_q == c_SAMP_C);
      w_bit_end = baud_tick && (tick_q == c_TICK_LAST);
      w_vote    = (samp_q[0] & samp_q[1]) | (samp_q[0] & w_rxs) | (samp_q[1] & w_rxs);
   end

   // Parity check against the already-assembled data word.
   generate
      if (PARITY == 0) begin : g_no_parity
         assign w_par_err = 1'b0;
      end else begin : g_parity
         assign w_par_err = (PARITY == 1) ? ~(^shift_q ^ w_vote) : (^shift_q ^ w_vote);
      end
   endgenerate

   // Frame FSM, bit timing, and the registered output/handshake stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         tick_q       <= '0;
         bit_q        <= '0;
         stop_q       <= 1'b0;
         samp_q       <= 2'b11;
         shift_q      <= '0;
         perr_q       <= 1'b0;
         ferr_q       <= 1'b0;
         ext_data_out <= '0;
         data_valid   <= 1'b0;
         parity_err   <= 1'b0;
         frame_err    <= 1'b0;
         overrun_err  <= 1'b0;
      end else begin
         // Consumer handshake; a completing frame below takes priority.
         if (data_valid && data_ready) begin
            data_valid <= 1'b0;
         end

         if (baud_tick && (state_q != S_IDLE) && (state_q != S_BREAK)) begin
            tick_q <= (tick_q == c_TICK_LAST) ? '0 : tick_q + TW'(1);
         end
         if (w_tick_a) samp_q[0] <= w_rxs;
         if (w_tick_b) samp_q[1] <= w_rxs;

         case (state_q)
            S_IDLE: begin
               if (baud_tick && !w_rxs) begin
                  state_q <= S_START;
                  tick_q  <= '0;
                  perr_q  <= 1'b0;
                  ferr_q  <= 1'b0;
               end
            end
            S_START: begin
               if (w_vote_pt && w_vote) begin
                  state_q <= S_IDLE;
               end else if (w_bit_end) begin
                  state_q <= S_DATA;
                  bit_q   <= '0;
               end
            end
            S_DATA: begin
               // LSB arrives first, so shifting right leaves it at bit 0.
               if (w_vote_pt) begin
                  shift_q <= {w_vote, shift_q[DATA_BITS-1:1]};
                  bit_q   <= bit_q + BW'(1);
               end
               if (w_bit_end && (bit_q == c_NBITS)) begin
                  state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
                  stop_q  <= 1'b0;
               end
            end
            S_PARITY: begin
               if (w_vote_pt) begin
                  perr_q <= w_par_err;
               end
               if (w_bit_end) begin
                  state_q <= S_STOP;
                  stop_q  <= 1'b0;
               end
            end
            S_STOP: begin
               if (w_vote_pt) begin
                  if (stop_q == c_LAST_STOP) begin
                     // Finish at mid-stop so the next start edge is caught.
                     ext_data_out <= shift_q;
                     parity_err   <= perr_q;
                     frame_err    <= ferr_q | ~w_vote;
                     overrun_err  <= data_valid && !data_ready;
                     data_valid   <= 1'b1;
                     state_q      <= w_rxs ? S_IDLE : S_BREAK;
                  end else begin
                     ferr_q <= ferr_q | ~w_vote;
                  end
               end else if (w_bit_end) begin
                  stop_q <= 1'b1;
               end
            end
            S_BREAK: begin
               // Hold off start detection until the line has gone high again.
               if (w_rxs) begin
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_param
//  Purpose  : Self-checking bench for uart_rx_param. Three instances cover
//             8N1/x16, 8E1/x8 and 7N2/x16 configurations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_param;

   logic clk = 1'b0;
   logic rst;
   logic baud_tick;
   logic rx0, rx1, rx2;
   logic rdy0, rdy1, rdy2;
   logic [7:0] dout0, dout1;
   logic [6:0] dout2;
   logic dv0, dv1, dv2, pe0, pe1, pe2, fe0, fe1, fe2, ov0, ov1, ov2;

   int n_cmp = 0;
   int n_bad = 0;
   int vcnt0 = 0;

   uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(2)) dut0 (
      .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx(rx0), .ext_data_out(dout0),
      .data_valid(dv0), .data_ready(rdy0), .parity_err(pe0), .frame_err(fe0), .overrun_err(ov0));

   uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(8), .PARITY(2), .STOP_BITS(1), .SYNC_STAGES(3)) dut1 (
      .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx(rx1), .ext_data_out(dout1),
      .data_valid(dv1), .data_ready(rdy1), .parity_err(pe1), .frame_err(fe1), .overrun_err(ov1));

   uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(2), .SYNC_STAGES(2)) dut2 (
      .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx(rx2), .ext_data_out(dout2),
      .data_valid(dv2), .data_ready(rdy2), .parity_err(pe2), .frame_err(fe2), .overrun_err(ov2));

   always #5 clk = ~clk;

   // One baud strobe every 4 clk, driven on the falling edge.
   initial begin
      baud_tick = 1'b0;
      forever begin
         repeat (3) @(negedge clk);
         baud_tick = 1'b1;
         @(negedge clk);
         baud_tick = 1'b0;
      end
   end

   // Count clk cycles with dut0 data_valid high (words seen when ready=1).
   always @(negedge clk) begin
      if (dv0 === 1'b1) vcnt0 <= vcnt0 + 1;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got time limit reached, required normal finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus helpers -------------------------------------
   task automatic tick_wait(input int n);
      repeat (n) begin
         @(posedge clk);
         while (baud_tick !== 1'b1) @(posedge clk);
      end
      @(negedge clk);
   endtask

   task automatic drive_rx(input int which, input logic v);
      case (which)
         0:       rx0 = v;
         1:       rx1 = v;
         default: rx2 = v;
      endcase
   endtask

   // Serial transmit model: bits[0] first, each held os baud ticks.
   task automatic send_raw(input int which, input logic [15:0] bits, input int nb, input int os);
      for (int i = 0; i < nb; i++) begin
         drive_rx(which, bits[i]);
         tick_wait(os);
      end
      drive_rx(which, 1'b1);
   endtask

   function automatic logic [15:0] frm0(input logic [7:0] d);
      return {6'b111111, 1'b1, d, 1'b0};
   endfunction

   function automatic logic [15:0] frm1(input logic [7:0] d, input logic p);
      return {5'b11111, 1'b1, p, d, 1'b0};
   endfunction

   function automatic logic [15:0] frm2(input logic [6:0] d, input logic s1, input logic s2);
      return {6'b111111, s2, s1, d, 1'b0};
   endfunction

   // Bounded wait for a word on the selected instance.
   task automatic wait_valid(input int which, output logic ok, output logic [8:0] d, output logic [2:0] fl);
      ok = 1'b0;
      d  = '0;
      fl = '0;
      for (int i = 0; i < 3000 && !ok; i++) begin
         @(negedge clk);
         case (which)
            0: if (dv0 === 1'b1) begin ok = 1'b1; d = {1'b0, dout0}; fl = {pe0, fe0, ov0}; end
            1: if (dv1 === 1'b1) begin ok = 1'b1; d = {1'b0, dout1}; fl = {pe1, fe1, ov1}; end
            default: if (dv2 === 1'b1) begin ok = 1'b1; d = {2'b0, dout2}; fl = {pe2, fe2, ov2}; end
         endcase
      end
   endtask

   // ---------------- tests -------------------------------------------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({dv0, dv1, dv2} !== 3'b000) begin
         n_bad++; $display("FAIL reset_valid: got %b required 000", {dv0, dv1, dv2});
      end
      n_cmp++;
      if ({dout0, dout1, dout2} !== 23'd0) begin
         n_bad++; $display("FAIL reset_data: got %h required 0", {dout0, dout1, dout2});
      end
      n_cmp++;
      if ({pe0, fe0, ov0, pe1, fe1, ov1, pe2, fe2, ov2} !== 9'd0) begin
         n_bad++; $display("FAIL reset_flags: got %b required 0", {pe0, fe0, ov0, pe1, fe1, ov1, pe2, fe2, ov2});
      end
   endtask

   task automatic test_basic();
      logic [7:0] d;
      logic ok, after;
      logic [8:0] got;
      logic [2:0] fl;
      rdy0 = 1'b1;
      for (int k = 0; k < 5; k++) begin
         d = (k == 0) ? 8'hB4 : 8'($urandom);
         after = 1'b1;
         fork
            send_raw(0, frm0(d), 10, 16);
            begin
               wait_valid(0, ok, got, fl);
               @(negedge clk);
               after = dv0;
            end
         join
         n_cmp++;
         if (!ok) begin n_bad++; $display("FAIL basic_timeout: got no data_valid, required word %h", d); end
         n_cmp++;
         if (got !== {1'b0, d}) begin n_bad++; $display("FAIL basic_data: got %h required %h", got, d); end
         n_cmp++;
         if (fl !== 3'b000) begin n_bad++; $display("FAIL basic_flags: got %b required 000", fl); end
         n_cmp++;
         if (after !== 1'b0) begin n_bad++; $display("FAIL basic_pulse: valid one clk later got %b required 0", after); end
         tick_wait($urandom_range(0, 6));
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] d;
      logic ok;
      logic [8:0] got;
      logic [2:0] fl;
      rdy0 = 1'b0;
      send_raw(0, frm0(8'hB4), 10, 16);
      n_cmp++;
      if ({dv0, dout0, ov0} !== {1'b1, 8'hB4, 1'b0}) begin
         n_bad++; $display("FAIL b2b_first: got v=%b d=%h ov=%b required v=1 d=b4 ov=0", dv0, dout0, ov0);
      end
      send_raw(0, frm0(8'hF1), 10, 16);
      n_cmp++;
      if ({dv0, dout0, ov0, pe0, fe0} !== {1'b1, 8'hF1, 3'b100}) begin
         n_bad++; $display("FAIL b2b_overrun: got v=%b d=%h ov=%b pe=%b fe=%b required v=1 d=f1 ov=1 pe=0 fe=0",
                           dv0, dout0, ov0, pe0, fe0);
      end
      rdy0 = 1'b1;
      @(negedge clk);
      rdy0 = 1'b0;
      n_cmp++;
      if ({dv0, dout0, ov0} !== {1'b0, 8'hF1, 1'b1}) begin
         n_bad++; $display("FAIL b2b_consume: got v=%b d=%h ov=%b required v=0 d=f1 ov=1", dv0, dout0, ov0);
      end
      rdy0 = 1'b1;
      d = 8'($urandom);
      fork
         send_raw(0, frm0(d), 10, 16);
         wait_valid(0, ok, got, fl);
      join
      n_cmp++;
      if (!ok || got !== {1'b0, d} || fl !== 3'b000) begin
         n_bad++; $display("FAIL b2b_after: got ok=%b d=%h fl=%b required ok=1 d=%h fl=000", ok, got, fl, d);
      end
   endtask

   task automatic test_glitch();
      int v;
      logic ok;
      logic [8:0] got;
      logic [2:0] fl;
      rdy0 = 1'b1;
      v = vcnt0;
      drive_rx(0, 1'b0);
      tick_wait(5);
      drive_rx(0, 1'b1);
      tick_wait(6);
      n_cmp++;
      if (vcnt0 !== v) begin n_bad++; $display("FAIL glitch_novalid: got %0d valid cycles required 0", vcnt0 - v); end
      fork
         send_raw(0, frm0(8'hA5), 10, 16);
         wait_valid(0, ok, got, fl);
      join
      n_cmp++;
      if (!ok || got !== 9'h0A5 || fl !== 3'b000) begin
         n_bad++; $display("FAIL glitch_recover: got ok=%b d=%h fl=%b required ok=1 d=a5 fl=000", ok, got, fl);
      end
   endtask

   task automatic test_break();
      int v;
      logic ok;
      logic [8:0] got;
      logic [2:0] fl;
      rdy0 = 1'b1;
      v = vcnt0;
      fork
         begin
            drive_rx(0, 1'b0);
            tick_wait(16 * 12);
            drive_rx(0, 1'b1);
         end
         wait_valid(0, ok, got, fl);
      join
      tick_wait(40);
      n_cmp++;
      if (!ok || got !== 9'h000 || fl !== 3'b010) begin
         n_bad++; $display("FAIL break_word: got ok=%b d=%h fl=%b required ok=1 d=00 fl=010", ok, got, fl);
      end
      n_cmp++;
      if (vcnt0 - v !== 1) begin n_bad++; $display("FAIL break_count: got %0d words required 1", vcnt0 - v); end
   endtask

   task automatic test_parity();
      logic [7:0] d;
      logic p, ok, exp_pe;
      logic [8:0] got;
      logic [2:0] fl;
      rdy1 = 1'b1;
      for (int k = 0; k < 5; k++) begin
         d = (k < 2) ? 8'hA5 : 8'($urandom);
         p = (k == 0) ? 1'b1 : (k == 1) ? 1'b0 : 1'($urandom);
         exp_pe = (($countones(d) + int'(p)) % 2) == 1;
         fork
            send_raw(1, frm1(d, p), 11, 8);
            wait_valid(1, ok, got, fl);
         join
         n_cmp++;
         if (!ok || got !== {1'b0, d}) begin
            n_bad++; $display("FAIL parity_data: got ok=%b d=%h required ok=1 d=%h", ok, got, d);
         end
         n_cmp++;
         if (fl !== {exp_pe, 2'b00}) begin
            n_bad++; $display("FAIL parity_flags: got %b required %b (p=%b)", fl, {exp_pe, 2'b00}, p);
         end
      end
   endtask

   task automatic test_stop2();
      logic [6:0] d;
      logic s1, s2, ok;
      logic [8:0] got;
      logic [2:0] fl;
      rdy2 = 1'b1;
      for (int k = 0; k < 3; k++) begin
         d  = (k == 0) ? 7'h55 : 7'($urandom);
         s1 = (k != 1);
         s2 = (k != 0);
         fork
            send_raw(2, frm2(d, s1, s2), 10, 16);
            wait_valid(2, ok, got, fl);
         join
         tick_wait(4);
         n_cmp++;
         if (!ok || got !== {2'b00, d}) begin
            n_bad++; $display("FAIL stop2_data: got ok=%b d=%h required ok=1 d=%h", ok, got, d);
         end
         n_cmp++;
         if (fl !== {1'b0, ~(s1 & s2), 1'b0}) begin
            n_bad++; $display("FAIL stop2_flags: got %b required %b (s1=%b s2=%b)", fl, {1'b0, ~(s1 & s2), 1'b0}, s1, s2);
         end
      end
   endtask

   task automatic test_reset_midframe();
      logic [3:0] part;
      logic ok;
      logic [8:0] got;
      logic [2:0] fl;
      int v;
      rdy0 = 1'b0;
      send_raw(0, frm0(8'($urandom) | 8'h01), 10, 16);
      part = 4'($urandom);
      drive_rx(0, 1'b0);
      tick_wait(16);
      for (int i = 0; i < 4; i++) begin
         drive_rx(0, part[i]);
         tick_wait(16);
      end
      drive_rx(0, 1'b1);
      tick_wait(8);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_cmp++;
      if ({dv0, dout0, pe0, fe0, ov0} !== 12'd0) begin
         n_bad++; $display("FAIL midreset_outputs: got v=%b d=%h pe=%b fe=%b ov=%b required all 0",
                           dv0, dout0, pe0, fe0, ov0);
      end
      rdy0 = 1'b1;
      v = vcnt0;
      tick_wait(20);
      n_cmp++;
      if (vcnt0 !== v) begin n_bad++; $display("FAIL midreset_spurious: got %0d valid cycles required 0", vcnt0 - v); end
      fork
         send_raw(0, frm0(8'h3C), 10, 16);
         wait_valid(0, ok, got, fl);
      join
      n_cmp++;
      if (!ok || got !== 9'h03C || fl !== 3'b000) begin
         n_bad++; $display("FAIL midreset_next: got ok=%b d=%h fl=%b required ok=1 d=3c fl=000", ok, got, fl);
      end
   endtask

   initial begin
      rst  = 1'b1;
      rx0  = 1'b1;
      rx1  = 1'b1;
      rx2  = 1'b1;
      rdy0 = 1'b1;
      rdy1 = 1'b1;
      rdy2 = 1'b1;
      test_reset();
      tick_wait(4);
      test_basic();
      test_back_to_back();
      test_glitch();
      test_break();
      test_parity();
      test_stop2();
      test_reset_midframe();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
